// File: rtl/latency_report.sv
// Reporting stage for the NoC latency monitor: counts accumulated packets, snapshots
// sum/min/max on window end, divides serially and streams a byte frame. CRC byte: LAT_REPORT_CRC_EN.
module latency_report #(
    parameter int SUM_W = 24,
    parameter int MIN_W = 16,
    parameter int MAX_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic             receive_finish_flag,
    input  logic [SUM_W-1:0] latency_sum_circuit,
    input  logic [MIN_W-1:0] latency_min_circuit,
    input  logic [MAX_W-1:0] latency_max_circuit,
    input  logic             report_ready,
    output logic             report_valid,
    output logic [7:0]       report_data,
    output logic             report_last,
    output logic             busy,
    output logic             report_overrun
);
    localparam int NB_CNT  = (CNT_W + 7) / 8;
    localparam int NB_SUM  = (SUM_W + 7) / 8;
    localparam int NB_MIN  = (MIN_W + 7) / 8;
    localparam int NB_MAX  = (MAX_W + 7) / 8;
    localparam int FRAME_B = 1 + 2 * NB_CNT + NB_SUM + NB_MIN + NB_MAX;
`ifdef LAT_REPORT_CRC_EN
    localparam int TOTAL_B = FRAME_B + 1;
`else
    localparam int TOTAL_B = FRAME_B;
`endif
    localparam int IDX_W = $clog2(TOTAL_B + 1);
    localparam int DIV_W = $clog2(SUM_W + 1);
    localparam logic [SUM_W-1:0] AVG_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DIV, S_SEND} state_t;

    state_t           state_q, state_d;
    logic [2:0]       en_q;
    logic [1:0]       flag_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       wcnt_q;
    logic [DIV_W-1:0] divc_q;
    logic [IDX_W-1:0] idx_q;
    logic [SUM_W-1:0] snap_sum_q, quo_q;
    logic [MIN_W-1:0] snap_min_q;
    logic [MAX_W-1:0] snap_max_q;
    logic [CNT_W-1:0] snap_cnt_q, rem_q, avg_q;
    logic             overrun_q;

    logic             flag_rise, accept, div_last, send_last;
    logic [CNT_W:0]   rem_sh, rem_sub;
    logic             rem_ge;
    logic [SUM_W-1:0] quo_nxt;
    logic [7:0]       frame_byte;

    assign flag_rise = receive_finish_flag & ~flag_q[0];
    assign accept    = report_valid & report_ready;
    assign div_last  = (divc_q == DIV_W'(SUM_W - 1));
    assign send_last = accept && (idx_q == IDX_W'(TOTAL_B - 1));

    // Same EN/flag delays as the accumulator so the count matches the running sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= '0;
            flag_q    <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            en_q   <= {en_q[1:0], EN};
            flag_q <= {flag_q[0], receive_finish_flag};
            if (en_q[2] && !flag_q[1] && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
            if (flag_rise && state_q != S_IDLE)
                overrun_q <= 1'b1;
        end
    end

    // One restoring step: dividend bits shift out of quo_q as quotient bits shift in.
    always_comb begin
        rem_sh  = {rem_q, quo_q[SUM_W-1]};
        rem_ge  = (rem_sh >= {1'b0, snap_cnt_q});
        rem_sub = rem_sh - {1'b0, snap_cnt_q};
        quo_nxt = {quo_q[SUM_W-2:0], rem_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (flag_rise)      state_d = S_WAIT;
            S_WAIT: if (wcnt_q == 2'd0) state_d = S_DIV;
            S_DIV:  if (div_last)       state_d = S_SEND;
            S_SEND: if (send_last)      state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

`ifdef LAT_REPORT_CRC_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int b = 0; b < 8; b++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else if (state_q == S_DIV) begin
            crc_q <= '0;
        end else if (state_q == S_SEND && accept && idx_q < IDX_W'(FRAME_B)) begin
            crc_q <= crc8_byte(crc_q, report_data);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q     <= '0;
            divc_q     <= '0;
            idx_q      <= '0;
            snap_sum_q <= '0;
            snap_min_q <= '0;
            snap_max_q <= '0;
            snap_cnt_q <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            avg_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (flag_rise) wcnt_q <= 2'd2;
                S_WAIT: begin
                    if (wcnt_q != 2'd0) begin
                        wcnt_q <= wcnt_q - 2'd1;
                    end else begin
                        snap_sum_q <= latency_sum_circuit;
                        snap_min_q <= latency_min_circuit;
                        snap_max_q <= latency_max_circuit;
                        snap_cnt_q <= cnt_q;
                        quo_q      <= latency_sum_circuit;
                        rem_q      <= '0;
                        divc_q     <= '0;
                    end
                end
                S_DIV: begin
                    divc_q <= divc_q + DIV_W'(1);
                    // A zero count skips the arithmetic but keeps the fixed cycle budget.
                    if (snap_cnt_q != '0) begin
                        quo_q <= quo_nxt;
                        rem_q <= rem_ge ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
                    end
                    if (div_last) begin
                        idx_q <= '0;
                        if (snap_cnt_q == '0 || quo_nxt > AVG_MAX)
                            avg_q <= '1;
                        else
                            avg_q <= quo_nxt[CNT_W-1:0];
                    end
                end
                S_SEND: if (accept) idx_q <= idx_q + IDX_W'(1);
                default: ;
            endcase
        end
    end

    // Frame image built from the shadow registers only; fields zero-padded, MSB byte first.
    logic [8*NB_CNT-1:0]  cnt_pad, avg_pad;
    logic [8*NB_SUM-1:0]  sum_pad;
    logic [8*NB_MIN-1:0]  min_pad;
    logic [8*NB_MAX-1:0]  max_pad;
    logic [8*FRAME_B-1:0] frame_v, frame_sh;

    always_comb begin
        cnt_pad = '0;
        avg_pad = '0;
        sum_pad = '0;
        min_pad = '0;
        max_pad = '0;
        cnt_pad[CNT_W-1:0] = snap_cnt_q;
        avg_pad[CNT_W-1:0] = avg_q;
        sum_pad[SUM_W-1:0] = snap_sum_q;
        min_pad[MIN_W-1:0] = snap_min_q;
        max_pad[MAX_W-1:0] = snap_max_q;
        frame_v    = {8'hA5, cnt_pad, sum_pad, min_pad, max_pad, avg_pad};
        frame_sh   = frame_v << {idx_q, 3'b000};
        frame_byte = frame_sh[8*FRAME_B-1 -: 8];
    end

    always_comb begin
        report_valid   = (state_q == S_SEND);
        report_data    = 8'h00;
        report_last    = 1'b0;
        busy           = (state_q == S_DIV) || (state_q == S_SEND);
        report_overrun = overrun_q;
        if (state_q == S_SEND) begin
            report_data = frame_byte;
`ifdef LAT_REPORT_CRC_EN
            if (idx_q == IDX_W'(FRAME_B))
                report_data = crc_q;
`endif
            report_last = (idx_q == IDX_W'(TOTAL_B - 1));
        end
    end

endmodule

// File: doc/latency_report.md
# latency_report

Downstream reporting stage for the NoC latency monitor. It watches the running sum/min/max latency outputs of the latency comparator and counts the packets that were accumulated. On the end of a measurement window (`receive_finish_flag` rising) it snapshots the statistics and computes the average latency with a serial divider. It then streams a byte-wide report frame over a valid/ready interface to the chip readout path.

## Interface
Parameters:
- `SUM_W`, 24: width of `latency_sum_circuit`; top level binds it to `SUM_WIDTH`.
- `MIN_W`, 16: width of `latency_min_circuit`; bound to `MIN_WIDTH`.
- `MAX_W`, 16: width of `latency_max_circuit`; bound to `MAX_WIDTH`.
- `CNT_W`, 16: packet counter width; the average field is also `CNT_W` wide.

Ports:
- `clk`  in  1  single clock, shared with the latency comparator.
- `rst_n`  in  1  asynchronous, active-low reset.
- `EN`  in  1  same per-packet enable that drives the comparator.
- `receive_finish_flag`  in  1  end-of-window flag, same signal as drives the comparator.
- `latency_sum_circuit`  in  SUM_W  running latency sum.
- `latency_min_circuit`  in  MIN_W  running minimum.
- `latency_max_circuit`  in  MAX_W  running maximum.
- `report_ready`  in  1  sink accepts a byte.
- `report_valid`  out  1  byte available.
- `report_data`  out  8  frame byte.
- `report_last`  out  1  final byte of the frame.
- `busy`  out  1  high from the snapshot until the last byte is accepted.
- `report_overrun`  out  1  sticky; a window end arrived while busy.

## Operation
- **Packet counter `pkt_cnt` (CNT_W).** Mirrors the accumulator gating exactly: EN passes through a 3-stage delay, the flag through a 2-stage delay. The counter increments when the EN delay-3 stage is 1 and the flag delay-2 stage is 0. It saturates at all-ones and clears only on reset, so it stays consistent with the cumulative sum.
- **Window end.** A rising edge of `receive_finish_flag` (registered 0, current 1) triggers the FSM.
- **FSM states.** IDLE → WAIT → DIV → SEND → IDLE.
  - **IDLE.** On a rising edge, go to WAIT and load the wait counter with 2.
  - **WAIT.** Counts down 2,1,0; the sum can still update during these cycles. On the cycle after 0, snapshot sum, min, max and `pkt_cnt` into shadow registers, assert `busy`, and enter DIV.
  - **DIV.** Restoring divide of the sum snapshot by the count snapshot, producing one quotient bit per cycle, MSB first, over exactly SUM_W cycles.
    - Average = quotient truncated toward zero, saturated to all-ones if it exceeds CNT_W bits.
    - If the count is 0, the average is all-ones and no divide is performed, but the state still spends SUM_W cycles so timing is fixed.
  - **SEND.** Byte index 0..N-1. Each field is zero-extended to whole bytes and sent MSB byte first.
    - Frame order: header `0xA5`, count, sum, min, max, average.
    - With default widths: 1+2+3+2+2+2 = 12 bytes.
    - Index advances only on `report_valid && report_ready`.
    - After the last byte is accepted: `busy`=0, return to IDLE.
- **Overrun.** A rising edge of the flag while not IDLE is dropped, and `report_overrun` is set until reset.
- **Idle updates.** The inputs may change freely while idle; only the shadow registers feed the frame.

## Timing
- **Reset values.** All outputs 0 except `report_data`=0x00. FSM in IDLE, counter 0, delay stages 0.
- **Reset mid-operation.** Asynchronously aborts the frame. `report_valid` drops immediately and no partial frame resumes.
- **Latency.** Let T be the cycle the flag is first sampled high.
  - Snapshot at T+3.
  - DIV spans T+4 .. T+3+SUM_W.
  - First `report_valid` at T+4+SUM_W (T+28 for defaults).
- **Handshake.** While `report_valid && !report_ready`, `report_data` and `report_last` are held stable. Valid never drops until acceptance. With ready held high, one byte is sent per cycle.
- **Back-to-back frames.** The first frame byte may not appear less than SUM_W+4 cycles after a window end. A new window end in the same cycle that the last byte is accepted counts as an overrun.

## Configuration
- **`LAT_REPORT_CRC_EN` defined.** The frame is followed by one CRC-8 byte (polynomial 0x07, init 0x00, no reflection, no final XOR) computed over all preceding bytes including the header. `report_last` moves to the CRC byte; the default frame becomes 13 bytes.
- **`LAT_REPORT_CRC_EN` undefined.** No CRC logic. `report_last` marks the average LSB byte; the default frame is 12 bytes.

## Test plan
- **Basic average.** Pulse EN for 4 packets, hold sum input at 40, min 7, max 13, then raise the finish flag → frame A5 0004 000028 0007 000D 000A, first valid at T+28, `report_last` on byte 11 (on byte 12 with CRC, value per CRC-8/0x07).
- **Zero packets.** Raise the finish flag with no EN → count 0000, average FFFF, rest of the frame intact.
- **Backpressure.** Hold `report_ready` low for 5 cycles at byte 3 → `report_data` is stable throughout and no byte is skipped or duplicated.
- **Overrun.** Raise the finish flag again during DIV → exactly one frame is sent and `report_overrun`=1 until reset.
- **Reset mid-frame.** Assert `rst_n` low at byte 6 → `report_valid`=0, `busy`=0 and `pkt_cnt`=0 immediately. A new window afterwards yields a complete fresh frame.
- **Saturation.** Drive 70000 EN cycles → count field FFFF and the average is computed against FFFF.
